// File: rtl/dc1_xbit_scrub_if.sv
// dc1_xbit_scrub_if -- signal bundle between the xbit-RAM scrubber and its
// environment (control handshake, RAM read/write ports, demand-write snoop,
// error reporting).
//   master : the scrubber side (drives requests, reports, status)
//   slave  : the environment side (drives start, RAM data, demand traffic)
interface dc1_xbit_scrub_if;
  // control handshake
  logic        start;
  logic        busy;
  logic        done;
  // scrub read port (36-bit RAM, bank 0 = even words, bank 1 = odd words)
  logic        rd_en;
  logic        rd_bank;
  logic [4:0]  rd_addr;
  logic [35:0] rd_data;
  logic        port_busy;
  // demand write snoop
  logic        dwr_en;
  logic        dwr_bank;
  logic [4:0]  dwr_addr;
  // correction write port
  logic        wr_en;
  logic        wr_bank;
  logic [4:0]  wr_addr;
  logic [35:0] wr_data;
  // error reporting
  logic        err_valid;
  logic [5:0]  err_idx;
  logic [3:0]  err_bytes;
  logic [7:0]  err_count;

  modport master (
    input  start, rd_data, port_busy, dwr_en, dwr_bank, dwr_addr,
    output busy, done, rd_en, rd_bank, rd_addr,
           wr_en, wr_bank, wr_addr, wr_data,
           err_valid, err_idx, err_bytes, err_count
  );

  modport slave (
    output start, rd_data, port_busy, dwr_en, dwr_bank, dwr_addr,
    input  busy, done, rd_en, rd_bank, rd_addr,
           wr_en, wr_bank, wr_addr, wr_data,
           err_valid, err_idx, err_bytes, err_count
  );
endinterface

// File: rtl/dc1_xbit_scrub.sv
// dc1_xbit_scrub -- walks all 64 words of the 36-bit xbit RAM (4 bytes, each
// with an even parity bit above it), reports words with bad parity and keeps
// a saturating error count.
// Build option: DC1_XBIT_SCRUB_FIX_EN -- when defined, an erroneous word is
// rewritten with regenerated parity unless a demand write to the same word
// overtakes it; when undefined the scrubber only reports and wr_en is 0.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous, active-high reset; abandons any pass in flight
//   bus  - dc1_xbit_scrub_if.master: start/busy/done, rd_* read request with
//          rd_data one cycle later, port_busy read-port arbitration,
//          dwr_* demand write snoop, wr_* correction write, err_* report.
module dc1_xbit_scrub (
  input  logic             clk,
  input  logic             rst,
  dc1_xbit_scrub_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
`ifdef DC1_XBIT_SCRUB_FIX_EN
    S_WRITE = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;          // {bank, addr} of the word in flight
  logic [7:0]  err_count_q, err_count_d;
  logic [3:0]  err_bytes;
  logic        word_bad;
  logic        last_word;
  state_t      adv_state;
  logic [5:0]  adv_idx;

  // Parity check on the word returned by the read issued in READ.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    err_bytes = '0;
    for (int k = 0; k < 4; k++) begin
      err_bytes[k] = bus.rd_data[9*k+8] ^ (^bus.rd_data[9*k +: 8]);
    end
  end

  assign word_bad  = |err_bytes;
  assign last_word = (idx_q == 6'd63);
  // The pass stops at word 63 instead of wrapping back to 0.
  assign adv_state = last_word ? S_DONE : S_READ;
  assign adv_idx   = last_word ? idx_q : idx_q + 6'd1;

`ifdef DC1_XBIT_SCRUB_FIX_EN
  logic        dwr_hit;
  logic [35:0] fix_data_q, fix_data_d;

  // A demand write to the word being scrubbed carries fresh data, so any
  // correction built from the stale read must be dropped.
  assign dwr_hit = bus.dwr_en && ({bus.dwr_bank, bus.dwr_addr} == idx_q);

  always_comb begin
    fix_data_d = '0;
    for (int k = 0; k < 4; k++) begin
      fix_data_d[9*k +: 9] = {^bus.rd_data[9*k +: 8], bus.rd_data[9*k +: 8]};
    end
  end

  // NOTE: fix_data_q is pure datapath, only consumed in WRITE after being loaded in CHECK, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_CHECK) fix_data_q <= fix_data_d;
  end
`else
  logic unused_dwr;
  assign unused_dwr = ^{bus.dwr_en, bus.dwr_bank, bus.dwr_addr};
`endif

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_count_d = err_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (!bus.port_busy) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (word_bad && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        state_d = adv_state;
        idx_d   = adv_idx;
`ifdef DC1_XBIT_SCRUB_FIX_EN
        if (word_bad && !dwr_hit) begin
          state_d = S_WRITE;
          idx_d   = idx_q;
        end
`endif
      end
`ifdef DC1_XBIT_SCRUB_FIX_EN
      S_WRITE: begin
        // Demand writes own the write port; a matching one cancels the fix.
        if (!bus.dwr_en || dwr_hit) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_count_q <= err_count_d;
    end
  end

  // Outputs. Pulses are masked by rst so a pass killed by reset issues no
  // read, write, report or done in its final cycle.
  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE) && !rst;
    bus.rd_en     = (state_q == S_READ) && !bus.port_busy && !rst;
    bus.rd_bank   = idx_q[5];
    bus.rd_addr   = idx_q[4:0];
    bus.err_valid = (state_q == S_CHECK) && word_bad && !rst;
    bus.err_idx   = idx_q;
    bus.err_bytes = err_bytes;
    bus.err_count = err_count_q;
    bus.wr_bank   = idx_q[5];
    bus.wr_addr   = idx_q[4:0];
`ifdef DC1_XBIT_SCRUB_FIX_EN
    bus.wr_en     = (state_q == S_WRITE) && !bus.dwr_en && !rst;
    bus.wr_data   = fix_data_q;
`else
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
`endif
  end

endmodule

// File: doc/dc1_xbit_scrub.md
DC1_XBIT_SCRUB -- requirements
Module: dc1_xbit_scrub

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port start, input, 1, begin a scrub pass; ignored while busy=1.
REQ-004 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-005 SHALL have port done, output, 1, one-cycle pulse ending a pass.
REQ-006 SHALL have port rd_en / rd_bank / rd_addr, outputs, 1/1/5, read request to the 36-bit xbit RAM (bank 0=even, 1=odd).
REQ-007 SHALL have port rd_data, input, 36, RAM data, valid exactly 1 cycle after rd_en (registered-address RAM).
REQ-008 SHALL have port port_busy, input, 1, read port owned by demand traffic; rd_en SHALL NOT assert while high.
REQ-009 SHALL have port dwr_en / dwr_bank / dwr_addr, inputs, 1/1/5, demand write to the RAM in the current cycle.
REQ-010 SHALL have port wr_en / wr_bank / wr_addr / wr_data, outputs, 1/1/5/36, correction write.
REQ-011 SHALL have port err_valid / err_idx / err_bytes, outputs, 1/6/4, one-cycle error report: {bank,addr} and failing-byte mask.
REQ-012 SHALL have port err_count, output, 8, saturating count of erroneous words since reset.

Function
REQ-013 SHALL hold states IDLE, READ, CHECK, WRITE, DONE in a 6-bit index idx={bank,addr} register.
REQ-014 IDLE: on start, idx<=0, go to READ.
REQ-015 READ: if port_busy=0, assert rd_en with rd_bank=idx[5], rd_addr=idx[4:0], go to CHECK; else stay in READ.
REQ-016 CHECK: byte k (k=0..3) = rd_data[9k+7:9k], parity = rd_data[9k+8]; err_bytes[k]=parity XOR (XOR-reduce of byte).
REQ-017 CHECK with err_bytes!=0: err_valid=1 for that cycle, err_idx=idx, err_count+=1 saturating at 255.
REQ-018 CHECK with no error, or no correction needed: if idx==63 go to DONE, else idx+=1, go to READ.
REQ-019 Corrected word SHALL keep all 32 data bits and regenerate all four parity bits as the XOR of each byte.
REQ-020 WRITE: assert wr_en only when dwr_en=0; otherwise stay in WRITE; after the write, advance as in REQ-018.
REQ-021 A demand write with {dwr_bank,dwr_addr}==idx during CHECK or WRITE SHALL cancel the pending correction; the error report is still issued.
REQ-022 DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-023 rd_en, wr_en, err_valid, and done SHALL each be single-cycle pulses, never asserted in IDLE.
REQ-024 idx SHALL NOT wrap: a pass covers exactly 64 words, 0..63.

Reset
REQ-025 On rst, state<=IDLE, idx<=0, err_count<=0; busy, done, rd_en, wr_en, and err_valid SHALL be 0 in the cycle after rst.
REQ-026 rst mid-pass SHALL abandon the pass with no write, no done, and no error report.

Configuration
REQ-027 Macro DC1_XBIT_SCRUB_FIX_EN defined: an erroneous word SHALL go CHECK->WRITE and be corrected per REQ-019..021.
REQ-028 Macro DC1_XBIT_SCRUB_FIX_EN undefined: report only; the WRITE state is absent and wr_en is tied 0.

Verification
REQ-029 Clean RAM, start, port_busy=0 -> 64 rd_en pulses, done at cycle 129 after start, err_count=0.
REQ-030 Word idx=37 with byte 2 parity flipped -> err_valid with err_idx=37, err_bytes=4'b0100, and err_count=1. With FIX_EN, also wr_en with wr_bank=1, wr_addr=5, and correct parity.
REQ-031 port_busy held high for 10 cycles in READ -> no rd_en during those cycles, pass resumes at the same idx, 10 extra cycles to done.
REQ-032 FIX_EN, error at idx=3, dwr_en to idx=3 in the WRITE cycle -> no wr_en for idx=3, err_count still increments.
REQ-033 err_count at 255, another erroneous word -> err_valid=1, err_count stays 255.
REQ-034 rst asserted at idx=20 -> busy=0 next cycle, no done, err_count=0; a new start begins at idx=0.
